// File: rtl/pe_stream_feeder_pkg.sv
// Shared definitions for the PE stream feeder: config field layout, FSM states
// and word-count helpers derived from the layer config.
package pe_stream_feeder_pkg;

    localparam int CFG_W      = 13;
    localparam int CFG_DW_BIT = 12;
    localparam int CFG_RS_LSB = 10;
    localparam int CFG_U_BIT  = 9;
    localparam int CFG_P_LSB  = 7;
    localparam int CFG_F_LSB  = 2;
    localparam int CFG_F_W    = 5;
    localparam int CFG_Q_LSB  = 0;
    localparam int CNT_W      = 5;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        FILTER,
        IFMAP,
        IPSUM,
        OPSUM,
        DONE
    } state_t;

    function automatic logic [CNT_W-1:0] rs_words(input logic [CFG_W-1:0] c);
        return CNT_W'(c[CFG_RS_LSB +: 2]) + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] p_words(input logic [CFG_W-1:0] c);
        return CNT_W'(c[CFG_P_LSB +: 2]) + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] filter_words(input logic [CFG_W-1:0] c);
        return rs_words(c) * p_words(c);
    endfunction

    function automatic logic [CNT_W-1:0] ifmap_first_words(input logic [CFG_W-1:0] c);
        return rs_words(c);
    endfunction

    function automatic logic [CNT_W-1:0] ifmap_next_words(input logic [CFG_W-1:0] c);
        return CNT_W'(c[CFG_U_BIT]) + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] nps_words(input logic [CFG_W-1:0] c);
        return c[CFG_DW_BIT] ? (CNT_W'(c[CFG_Q_LSB +: 2]) + CNT_W'(1)) : p_words(c);
    endfunction

endpackage

// File: rtl/pe_rd_stream.sv
// GLB read issue and 2-entry skid buffer driving one valid/ready stream;
// reloaded with a new base/count for each stream it serves.
module pe_rd_stream
    import pe_stream_feeder_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int ADDR_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [ADDR_W-1:0]    i_base,
    input  logic [CNT_W-1:0]     i_count,
    output logic                 o_rd_en,
    output logic [ADDR_W-1:0]    o_rd_addr,
    input  logic [DATA_BITS-1:0] i_rd_data,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_data,
    input  logic                 i_ready,
    output logic                 o_finished
);

    logic [ADDR_W-1:0]    r_addr;
    logic [CNT_W-1:0]     r_left;
    logic                 r_inflight;
    logic [1:0]           r_occ;
    logic [DATA_BITS-1:0] r_buf [2];

    logic       w_pop;
    logic       w_issue;
    logic [2:0] w_slots;
    logic [1:0] w_wr_pos;
    logic       w_wr_idx;

    assign o_valid  = (r_occ != 2'd0);
    assign o_data   = r_buf[0];
    assign w_pop    = o_valid && i_ready;
    // Occupancy counted after this cycle's pop so a steady stream sustains 1 word/cycle.
    assign w_slots  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue  = (r_left != '0) && (w_slots < 3'd2);
    assign w_wr_pos = r_occ - {1'b0, w_pop};
    assign w_wr_idx = w_wr_pos[0];

    assign o_rd_en    = w_issue;
    assign o_rd_addr  = r_addr;
    assign o_finished = (r_left == '0) && !r_inflight && (r_occ == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_left     <= '0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
        end else begin
            if (i_load) begin
                r_addr <= i_base;
                r_left <= i_count;
            end else if (w_issue) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_left <= r_left - CNT_W'(1);
            end
            r_inflight <= w_issue;
            r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
            if (w_pop) r_buf[0] <= r_buf[1];
            if (r_inflight) r_buf[w_wr_idx] <= i_rd_data;
        end
    end

endmodule

// File: rtl/pe_stream_feeder.sv
// Initiator-side PE driver: configures the PE, streams filter/ifmap/ipsum words
// from the GLB and writes returned opsum words back, column by column.
module pe_stream_feeder
    import pe_stream_feeder_pkg::*;
#(
    parameter int DATA_BITS   = 32,
    parameter int ADDR_W      = 16,
    parameter int CONFIG_SIZE = 13
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CONFIG_SIZE-1:0] cfg,
    input  logic [ADDR_W-1:0]      filter_base,
    input  logic [ADDR_W-1:0]      ifmap_base,
    input  logic [ADDR_W-1:0]      ipsum_base,
    input  logic [ADDR_W-1:0]      opsum_base,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_rd_addr,
    input  logic [DATA_BITS-1:0]   mem_rd_data,
    output logic                   mem_wr_en,
    output logic [ADDR_W-1:0]      mem_wr_addr,
    output logic [DATA_BITS-1:0]   mem_wr_data,
    output logic                   pe_en,
    output logic [CONFIG_SIZE-1:0] pe_config,
    output logic [DATA_BITS-1:0]   filter,
    output logic [DATA_BITS-1:0]   ifmap,
    output logic [DATA_BITS-1:0]   ipsum,
    output logic                   filter_valid,
    output logic                   ifmap_valid,
    output logic                   ipsum_valid,
    input  logic                   filter_ready,
    input  logic                   ifmap_ready,
    input  logic                   ipsum_ready,
    input  logic [DATA_BITS-1:0]   opsum,
    input  logic                   opsum_valid,
    output logic                   opsum_ready
);

    state_t                 r_state, w_next;
    logic [CONFIG_SIZE-1:0] r_cfg;
    logic [ADDR_W-1:0]      r_flt_base, r_if_ptr, r_ps_ptr, r_wr_addr;
    logic [CFG_F_W-1:0]     r_col;
    logic [CNT_W-1:0]       r_k;

    logic                   w_load;
    logic [ADDR_W-1:0]      w_base;
    logic [CNT_W-1:0]       w_count;
    logic [CNT_W-1:0]       w_nps;
    logic                   w_acc, w_last_k, w_last_col;
    logic                   w_rd_en, w_valid, w_ready, w_fin;
    logic [ADDR_W-1:0]      w_rd_addr;
    logic [DATA_BITS-1:0]   w_data;

    assign w_nps      = nps_words(r_cfg);
    assign w_acc      = (r_state == OPSUM) && opsum_valid;
    assign w_last_k   = w_acc && (r_k == w_nps - CNT_W'(1));
    assign w_last_col = (r_col == r_cfg[CFG_F_LSB +: CFG_F_W]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // The stream is reloaded on the transition cycle so its first read issues on state entry.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_base  = r_flt_base;
        w_count = filter_words(r_cfg);
        case (r_state)
            IDLE:   if (start) w_next = CFG;
            CFG: begin
                w_next = FILTER;
                w_load = 1'b1;
            end
            FILTER: if (w_fin) begin
                w_next  = IFMAP;
                w_load  = 1'b1;
                w_base  = r_if_ptr;
                w_count = ifmap_first_words(r_cfg);
            end
            IFMAP:  if (w_fin) begin
                w_next  = IPSUM;
                w_load  = 1'b1;
                w_base  = r_ps_ptr;
                w_count = w_nps;
            end
            IPSUM:  if (w_fin) w_next = OPSUM;
            OPSUM:  if (w_last_k) begin
                if (w_last_col) begin
                    w_next = DONE;
                end else begin
                    w_next  = IFMAP;
                    w_load  = 1'b1;
                    w_base  = r_if_ptr;
                    w_count = ifmap_next_words(r_cfg);
                end
            end
            DONE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg      <= '0;
            r_flt_base <= '0;
            r_if_ptr   <= '0;
            r_ps_ptr   <= '0;
            r_wr_addr  <= '0;
            r_col      <= '0;
            r_k        <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_cfg      <= cfg;
                r_flt_base <= filter_base;
                r_if_ptr   <= ifmap_base;
                r_ps_ptr   <= ipsum_base;
                r_wr_addr  <= opsum_base;
                r_col      <= '0;
                r_k        <= '0;
            end
            if (w_load && w_next == IFMAP) r_if_ptr <= r_if_ptr + ADDR_W'(w_count);
            if (w_load && w_next == IPSUM) r_ps_ptr <= r_ps_ptr + ADDR_W'(w_count);
            if (w_acc) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
                r_k       <= w_last_k ? '0 : r_k + CNT_W'(1);
                if (w_last_k && !w_last_col) r_col <= r_col + CFG_F_W'(1);
            end
        end
    end

    pe_rd_stream #(
        .DATA_BITS (DATA_BITS),
        .ADDR_W    (ADDR_W)
    ) u_stream (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_base     (w_base),
        .i_count    (w_count),
        .o_rd_en    (w_rd_en),
        .o_rd_addr  (w_rd_addr),
        .i_rd_data  (mem_rd_data),
        .o_valid    (w_valid),
        .o_data     (w_data),
        .i_ready    (w_ready),
        .o_finished (w_fin)
    );

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            FILTER:  w_ready = filter_ready;
            IFMAP:   w_ready = ifmap_ready;
            IPSUM:   w_ready = ipsum_ready;
            default: w_ready = 1'b0;
        endcase
    end

    assign busy         = (r_state != IDLE) && (r_state != DONE);
    assign done         = (r_state == DONE);
    assign pe_en        = (r_state == CFG);
    assign pe_config    = busy ? r_cfg : '0;
    assign filter_valid = (r_state == FILTER) && w_valid;
    assign ifmap_valid  = (r_state == IFMAP)  && w_valid;
    assign ipsum_valid  = (r_state == IPSUM)  && w_valid;
    assign filter       = (r_state == FILTER) ? w_data : '0;
    assign ifmap        = (r_state == IFMAP)  ? w_data : '0;
    assign ipsum        = (r_state == IPSUM)  ? w_data : '0;
    assign mem_rd_en    = w_rd_en;
    assign mem_rd_addr  = w_rd_en ? w_rd_addr : '0;
    assign opsum_ready  = (r_state == OPSUM);
    assign mem_wr_en    = w_acc;
    assign mem_wr_addr  = w_acc ? r_wr_addr : '0;
    assign mem_wr_data  = w_acc ? opsum : '0;

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Directed + randomized bench for pe_stream_feeder with a GLB/PE model and a
// word-list reference model built from the layer config arithmetic.
module tb_pe_stream_feeder;

    logic        clk, rst_n, start;
    logic [12:0] cfg;
    logic [15:0] filter_base, ifmap_base, ipsum_base, opsum_base;
    logic        busy, done, mem_rd_en, mem_wr_en, pe_en;
    logic [15:0] mem_rd_addr, mem_wr_addr;
    logic [31:0] mem_rd_data, mem_wr_data, filter, ifmap, ipsum, opsum;
    logic [12:0] pe_config;
    logic        filter_valid, ifmap_valid, ipsum_valid;
    logic        filter_ready, ifmap_ready, ipsum_ready;
    logic        opsum_valid, opsum_ready;

    pe_stream_feeder #(.DATA_BITS(32), .ADDR_W(16), .CONFIG_SIZE(13)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg(cfg),
        .filter_base(filter_base), .ifmap_base(ifmap_base),
        .ipsum_base(ipsum_base), .opsum_base(opsum_base),
        .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .pe_en(pe_en), .pe_config(pe_config),
        .filter(filter), .ifmap(ifmap), .ipsum(ipsum),
        .filter_valid(filter_valid), .ifmap_valid(ifmap_valid), .ipsum_valid(ipsum_valid),
        .filter_ready(filter_ready), .ifmap_ready(ifmap_ready), .ipsum_ready(ipsum_ready),
        .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] memf(input logic [15:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'hC0FFEE11;
    endfunction

    function automatic logic any_out();
        return |{busy, done, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
                 pe_en, pe_config, filter, ifmap, ipsum, filter_valid, ifmap_valid,
                 ipsum_valid, opsum_ready};
    endfunction

    logic [15:0] ra[$];
    logic [15:0] wa[$];
    logic [31:0] fd[$], id[$], pd[$];
    int          if_cnt[32], ps_cnt[32];
    int          pe_cnt, pe_cyc, f_first, f_last, done_cyc, last_wr_cyc;
    int          stab_err, wr_err, excl_err, cfg_err;
    bit          got_done, aborted;
    logic [12:0] pe_cfg_obs;
    logic        pend;
    logic [15:0] pend_a;
    logic        sv[3], sr[3];
    logic [31:0] sd[3];

    task automatic run(input string rn, input logic [12:0] c,
                       input logic [15:0] fb, input logic [15:0] ib,
                       input logic [15:0] pb, input logic [15:0] ob,
                       input bit thr, input bit restart, input bit abort);
        int rs, u, p, q, ncol, nps, bad, col;
        logic [15:0] exp_ra[$];
        logic cv[3], cr[3];
        logic [31:0] cd[3];
        rs   = int'(c[11:10]) + 1;
        u    = int'(c[9]) + 1;
        p    = int'(c[8:7]) + 1;
        q    = int'(c[1:0]) + 1;
        ncol = int'(c[6:2]) + 1;
        nps  = c[12] ? q : p;
        exp_ra.delete();
        for (int i = 0; i < p * rs; i++) exp_ra.push_back(fb + 16'(i));
        begin
            int ioff, poff;
            ioff = 0; poff = 0;
            for (int cc = 0; cc < ncol; cc++) begin
                for (int i = 0; i < (cc == 0 ? rs : u); i++) begin
                    exp_ra.push_back(ib + 16'(ioff)); ioff++;
                end
                for (int i = 0; i < nps; i++) begin
                    exp_ra.push_back(pb + 16'(poff)); poff++;
                end
            end
        end
        ra.delete(); wa.delete(); fd.delete(); id.delete(); pd.delete();
        for (int i = 0; i < 32; i++) begin if_cnt[i] = 0; ps_cnt[i] = 0; end
        pe_cnt = 0; pe_cyc = -1; f_first = -1; f_last = -1; done_cyc = -1; last_wr_cyc = -100;
        stab_err = 0; wr_err = 0; excl_err = 0; cfg_err = 0;
        got_done = 0; aborted = 0; pe_cfg_obs = '0; pend = 0; pend_a = '0;
        for (int i = 0; i < 3; i++) begin sv[i] = 0; sr[i] = 0; sd[i] = '0; end

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            mem_rd_data = pend ? memf(pend_a) : 32'h0;
            start = (cyc == 0) || (restart && cyc == 9);
            if (cyc == 0) begin
                cfg = c; filter_base = fb; ifmap_base = ib; ipsum_base = pb; opsum_base = ob;
            end else if (restart && cyc == 9) begin
                cfg = ~c; filter_base = 16'h7777; ifmap_base = 16'h8888;
                ipsum_base = 16'h9999; opsum_base = 16'hAAAA;
            end
            filter_ready = thr ? ($urandom_range(0, 99) >= 30) : 1'b1;
            ifmap_ready  = thr ? ($urandom_range(0, 99) >= 30) : 1'b1;
            ipsum_ready  = thr ? ($urandom_range(0, 99) >= 30) : 1'b1;
            opsum_valid  = thr ? ($urandom_range(0, 99) >= 30) : 1'b1;
            opsum        = $urandom();
            #1;
            pend = mem_rd_en; pend_a = mem_rd_addr;
            if (mem_rd_en) ra.push_back(mem_rd_addr);
            if (pe_en) begin pe_cnt++; pe_cyc = cyc; pe_cfg_obs = pe_config; end
            if (busy && pe_config !== c) cfg_err++;
            col = wa.size() / nps;
            if (col > 31) col = 31;
            if (filter_valid && filter_ready) begin
                fd.push_back(filter);
                if (f_first < 0) f_first = cyc;
                f_last = cyc;
            end
            if (ifmap_valid && ifmap_ready) begin id.push_back(ifmap); if_cnt[col]++; end
            if (ipsum_valid && ipsum_ready) begin pd.push_back(ipsum); ps_cnt[col]++; end
            if (int'(filter_valid) + int'(ifmap_valid) + int'(ipsum_valid) > 1) excl_err++;
            if (mem_wr_en !== (opsum_valid && opsum_ready)) wr_err++;
            if (mem_wr_en) begin
                if (mem_wr_data !== opsum) wr_err++;
                wa.push_back(mem_wr_addr);
                last_wr_cyc = cyc;
            end
            cv[0] = filter_valid; cr[0] = filter_ready; cd[0] = filter;
            cv[1] = ifmap_valid;  cr[1] = ifmap_ready;  cd[1] = ifmap;
            cv[2] = ipsum_valid;  cr[2] = ipsum_ready;  cd[2] = ipsum;
            for (int i = 0; i < 3; i++) begin
                if (sv[i] && !sr[i] && (!cv[i] || cd[i] !== sd[i])) stab_err++;
                sv[i] = cv[i]; sr[i] = cr[i]; sd[i] = cd[i];
            end
            if (abort && ipsum_valid) begin
                rst_n = 1'b0;
                #1;
                chk({rn, ":rst_outputs_zero"}, 64'(any_out()), 64'd0);
                aborted = 1;
                break;
            end
            if (done) begin got_done = 1; done_cyc = cyc; break; end
        end
        start = 1'b0;

        if (abort) begin
            chk({rn, ":reached_ipsum"}, 64'(aborted), 64'd1);
            chk({rn, ":no_done"}, 64'(got_done), 64'd0);
            return;
        end

        chk({rn, ":done_seen"}, 64'(got_done), 64'd1);
        chk({rn, ":pe_en_count"}, 64'(pe_cnt), 64'd1);
        chk({rn, ":pe_config"}, 64'(pe_cfg_obs), 64'(c));
        chk({rn, ":cfg_held"}, 64'(cfg_err), 64'd0);
        chk({rn, ":rd_count"}, 64'(ra.size()), 64'(exp_ra.size()));
        bad = 0;
        for (int i = 0; i < ra.size() && i < exp_ra.size(); i++) if (ra[i] !== exp_ra[i]) bad++;
        chk({rn, ":rd_addr_seq_bad"}, 64'(bad), 64'd0);
        chk({rn, ":filter_count"}, 64'(fd.size()), 64'(p * rs));
        bad = 0;
        foreach (fd[i]) if (fd[i] !== memf(fb + 16'(i))) bad++;
        chk({rn, ":filter_data_bad"}, 64'(bad), 64'd0);
        chk({rn, ":ifmap_count"}, 64'(id.size()), 64'(rs + u * (ncol - 1)));
        bad = 0;
        foreach (id[i]) if (id[i] !== memf(ib + 16'(i))) bad++;
        chk({rn, ":ifmap_data_bad"}, 64'(bad), 64'd0);
        chk({rn, ":ipsum_count"}, 64'(pd.size()), 64'(nps * ncol));
        bad = 0;
        foreach (pd[i]) if (pd[i] !== memf(pb + 16'(i))) bad++;
        chk({rn, ":ipsum_data_bad"}, 64'(bad), 64'd0);
        bad = 0;
        for (int cc = 0; cc < ncol; cc++) begin
            if (if_cnt[cc] != (cc == 0 ? rs : u)) bad++;
            if (ps_cnt[cc] != nps) bad++;
        end
        chk({rn, ":per_column_counts_bad"}, 64'(bad), 64'd0);
        chk({rn, ":wr_count"}, 64'(wa.size()), 64'(nps * ncol));
        bad = 0;
        foreach (wa[i]) if (wa[i] !== ob + 16'(i)) bad++;
        chk({rn, ":wr_addr_bad"}, 64'(bad), 64'd0);
        chk({rn, ":wr_handshake_err"}, 64'(wr_err), 64'd0);
        chk({rn, ":hold_while_stalled_err"}, 64'(stab_err), 64'd0);
        chk({rn, ":one_valid_err"}, 64'(excl_err), 64'd0);
        chk({rn, ":done_after_last_wr"}, 64'(done_cyc), 64'(last_wr_cyc + 1));
        if (!thr) begin
            chk({rn, ":first_filter_latency"}, 64'(f_first), 64'(pe_cyc + 3));
            chk({rn, ":filter_back_to_back"}, 64'(f_last - f_first), 64'(p * rs - 1));
        end
        repeat (3) @(negedge clk);
        #1;
        chk({rn, ":idle_after_done"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg = '0;
        filter_base = '0; ifmap_base = '0; ipsum_base = '0; opsum_base = '0;
        mem_rd_data = '0; opsum = '0; opsum_valid = 1'b0;
        filter_ready = 1'b0; ifmap_ready = 1'b0; ipsum_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs_zero", 64'(any_out()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // cfg fields: {dw, rs-1, U-1, p-1, F, q-1}
        run("base",   {1'b0, 2'd2, 1'b0, 2'd1, 5'd1, 2'd0}, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 1, 0);
        run("thrtl",  {1'b0, 2'd2, 1'b0, 2'd1, 5'd1, 2'd0}, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1, 1, 0);
        run("dwise",  {1'b1, 2'd2, 1'b0, 2'd0, 5'd0, 2'd3}, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 0, 0, 0);
        run("u2f2",   {1'b0, 2'd2, 1'b1, 2'd1, 5'd2, 2'd0}, 16'h0500, 16'h0600, 16'h0700, 16'h0800, 1, 0, 0);
        run("wrap",   {1'b0, 2'd2, 1'b0, 2'd0, 5'd0, 2'd0}, 16'h0010, 16'hFFFE, 16'hFFFF, 16'hFFFD, 0, 0, 0);
        run("abort",  {1'b0, 2'd2, 1'b0, 2'd1, 5'd1, 2'd0}, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run("post_rst", {1'b0, 2'd2, 1'b0, 2'd1, 5'd1, 2'd0}, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            run($sformatf("rand%0d", k), 13'($urandom()), 16'($urandom()), 16'($urandom()),
                16'($urandom()), 16'($urandom()), 1, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pe_stream_feeder.md
Name: pe_stream_feeder

Overview:
- Initiator-side driver for one PE. Sits between the GLB (single-port word memory, 1-cycle read latency) and a PE's valid/ready channels.
- Issues PE_en with the layer config, then streams filter words, per-column ifmap words and ipsum words into the PE.
- Collects opsum words from the PE and writes them back to the GLB, until all F+1 output columns are done.

Parameters:
- DATA_BITS, 32, width of every data word (4 x 8-bit elements packed, element 0 in [7:0])
- ADDR_W, 16, GLB word-address width
- CONFIG_SIZE, 13, config width: [12] depthwise, [11:10] rs-1, [9] U-1, [8:7] p-1, [6:2] F, [1:0] q-1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle launch pulse; ignored while busy
- cfg  in  CONFIG_SIZE  layer config, sampled on start
- filter_base / ifmap_base / ipsum_base / opsum_base  in  ADDR_W each  GLB word base addresses, sampled on start
- busy  out  1  high from the start-accept cycle until done
- done  out  1  one-cycle pulse after the final opsum write
- mem_rd_en  out  1  GLB read strobe
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  DATA_BITS  read data, valid the cycle after mem_rd_en
- mem_wr_en  out  1  GLB write strobe
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  DATA_BITS  write data
- pe_en  out  1  one-cycle PE enable
- pe_config  out  CONFIG_SIZE  config presented with pe_en
- filter / ifmap / ipsum  out  DATA_BITS each  PE input data
- filter_valid / ifmap_valid / ipsum_valid  out  1 each  PE input valids
- filter_ready / ifmap_ready / ipsum_ready  in  1 each  PE input readies
- opsum  in  DATA_BITS  PE output data
- opsum_valid  in  1  PE output valid
- opsum_ready  out  1  accept opsum

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, stream buffer empty. Reset mid-operation aborts immediately; no done pulse.
- Derived values:
  - rs = cfg[11:10]+1, U = cfg[9]+1, p = cfg[8:7]+1, q = cfg[1:0]+1, ncol = F+1
  - nps = q if depthwise, else p
  - filter words = p*rs
  - ifmap words: rs for column 0, U for every later column
  - ipsum and opsum words per column = nps
- FSM transitions:
  - IDLE: start -> CFG.
  - CFG: pe_en=1 and pe_config=cfg for exactly one cycle; pe_config stays at cfg while busy -> FILTER.
  - FILTER: send all filter words -> IFMAP.
  - IFMAP: send this column's ifmap words -> IPSUM.
  - IPSUM: send nps words -> OPSUM.
  - OPSUM: opsum_ready=1 in this state only. Each accepted opsum (valid && ready) is written the same cycle to opsum_base + col*nps + k.
    - After nps accepts: if col==F -> DONE, else col++ -> IFMAP.
  - DONE: done=1 for one cycle, busy drops -> IDLE.
- Addressing:
  - Each stream reads sequentially from its base.
  - ifmap and ipsum pointers persist across columns and are not rewound; the ifmap pointer advances rs, then U per column.
  - All address arithmetic wraps modulo 2^ADDR_W.
- Stream stage (active in FILTER, IFMAP, IPSUM):
  - 2-entry buffer in front of the PE channel; only the active state's valid is driven.
  - A read is issued when words remain and (buffer occupancy + reads in flight) < 2.
  - Throughput is 1 word/cycle while ready is held high.
  - First valid appears 2 cycles after entering the state.
  - Once valid is high, data and valid stay stable until ready.
  - The state is left only when all words are handshaked and the buffer is empty; no reads are issued beyond the word count.
- Simultaneous events: a buffer push and pop in the same cycle keeps occupancy unchanged; a buffer pop and a new read issue in the same cycle are legal.
- Passthrough: data is passed unmodified (the PE applies its own ifmap offset).

Decomposition:
- Shared package:
  - config field positions and widths
  - FSM state enum: IDLE, CFG, FILTER, IFMAP, IPSUM, OPSUM, DONE
  - helper functions for word counts (filter, ifmap-first, ifmap-next, nps)
- One sub-module, pe_rd_stream:
  - GLB read issue plus the 2-entry skid buffer
  - inputs: load, base, count; output: a valid/ready stream and a finished flag
  - instantiated once and time-shared across the three input streams

Test Plan:
- Non-depthwise, cfg rs=3 U=1 p=2 q=1 F=1, ready tied high:
  - exactly 1 pe_en pulse; 6 filter handshakes at filter_base..+5
  - ifmap 3 words then 1 word; ipsum 2 words per column
  - opsum writes to opsum_base+0..3; done 1 cycle after the 4th write
  - back-to-back handshakes at 1 word/cycle
- Random ready/opsum_valid throttling (~30% low) on the same config: data and valid held stable while ready is low; word counts and addresses identical to the unthrottled run.
- Depthwise, rs=3 q=4 p=1 F=0: nps=4, so ipsum and opsum are 4 words each; filter 3 words.
- U=2, F=2: ifmap reads rs, 2, 2 words from consecutive addresses with no rewind.
- Address wrap: ifmap_base=0xFFFE with 3 words reads 0xFFFE, 0xFFFF, 0x0000.
- Misc:
  - start pulse during busy is ignored.
  - rst_n asserted mid-IPSUM: all outputs 0 the same cycle; a later start runs cleanly.
